if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. It owns the PC and issues one outstanding instruction-memory request at a time on an SRAM-like req/addr_ok/data_ok bus. It presents {pc, inst, address-exception} to IF/ID, inserting a zero bubble whenever no fetched instruction is ready. It applies branch redirects and exception/eret flushes, and discards in-flight responses that a flush has cancelled.

---
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding on the
// instruction bus, and presents {pc, inst, exc} to IF/ID through a one-entry buffer.
//
// state  | meaning
// S_REQ  | idle or requesting; misaligned PCs are turned into exception entries here
// S_WAIT | request accepted, waiting for data_ok to fill the buffer
// S_DROP | request cancelled by a flush, waiting for data_ok to discard it
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        addr_exception_o,
    output logic        if_valid_o
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic        buf_valid_q;
    logic [31:0] buf_pc_q;
    logic [31:0] buf_inst_q;
    logic        buf_exc_q;
    logic        redir_valid_q;
    logic [31:0] redir_target_q;

    logic        aligned;
    logic        buf_free;
    logic        req;
    logic        redir_valid_eff;
    logic [31:0] redir_target_eff;
    logic [31:0] pc_next;

    assign aligned  = (pc_q[1:0] == 2'b00);
    // Buffer can take a new entry if it is empty or being consumed this cycle.
    assign buf_free = !buf_valid_q || !stall_i;
    assign req      = rst_ni && (state_q == S_REQ) && buf_free && aligned;

    // A branch in the same cycle as an advance must already steer that advance.
    assign redir_valid_eff  = branch_i || redir_valid_q;
    assign redir_target_eff = branch_i ? branch_target_i : redir_target_q;
    assign pc_next          = redir_valid_eff ? redir_target_eff : pc_q + 32'd4;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            buf_valid_q    <= 1'b0;
            buf_pc_q       <= 32'h0;
            buf_inst_q     <= 32'h0;
            buf_exc_q      <= 1'b0;
            redir_valid_q  <= 1'b0;
            redir_target_q <= 32'h0;
        end else if (flush_i) begin
            pc_q          <= flush_pc_i;
            buf_valid_q   <= 1'b0;
            redir_valid_q <= 1'b0;
            case (state_q)
                S_WAIT, S_DROP: state_q <= inst_data_ok_i ? S_REQ : S_DROP;
                S_REQ:          state_q <= (req && inst_addr_ok_i) ? S_DROP : S_REQ;
                default:        state_q <= S_REQ;
            endcase
        end else begin
            redir_valid_q  <= redir_valid_eff;
            redir_target_q <= redir_target_eff;
            if (buf_valid_q && !stall_i) begin
                buf_valid_q <= 1'b0;
            end
            case (state_q)
                S_REQ: begin
                    if (aligned) begin
                        if (req && inst_addr_ok_i) begin
                            state_q <= S_WAIT;
                        end
                    end else if (buf_free) begin
                        buf_valid_q   <= 1'b1;
                        buf_pc_q      <= pc_q;
                        buf_inst_q    <= 32'h0;
                        buf_exc_q     <= 1'b1;
                        pc_q          <= pc_next;
                        redir_valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok_i) begin
                        buf_valid_q   <= 1'b1;
                        buf_pc_q      <= pc_q;
                        buf_inst_q    <= inst_rdata_i;
                        buf_exc_q     <= 1'b0;
                        pc_q          <= pc_next;
                        redir_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (inst_data_ok_i) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign inst_req_o       = req;
    assign inst_addr_o      = pc_q;
    assign if_valid_o       = buf_valid_q;
    assign if_pc_o          = buf_valid_q ? buf_pc_q : 32'h0;
    assign if_inst_o        = buf_valid_q ? buf_inst_q : 32'h0;
    assign addr_exception_o = buf_valid_q && buf_exc_q;

endmodule
